// File: rtl/count_binary_pio.sv
`default_nettype none
// ============================================================================
// Module   : count_binary_pio
// Purpose  : Avalon-MM GPIO slave with per-bit direction, synchronised inputs,
//            maskable edge-capture interrupt and atomic bit set/clear writes.
// Revision : 1.0
// ============================================================================
module count_binary_pio #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [WIDTH-1:0] DIR_RESET   = {WIDTH{1'b1}},
  parameter int               EDGE_TYPE   = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe,
  output logic             irq
);

  localparam logic [2:0] c_ADDR_DATA     = 3'd0;
  localparam logic [2:0] c_ADDR_DIR      = 3'd1;
  localparam logic [2:0] c_ADDR_IRQMASK  = 3'd2;
  localparam logic [2:0] c_ADDR_EDGECAP  = 3'd3;
  localparam logic [2:0] c_ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] c_ADDR_OUTCLEAR = 3'd5;

  logic [WIDTH-1:0] r_data_out;
  logic [WIDTH-1:0] r_dir;
  logic [WIDTH-1:0] r_irqmask;
  logic [WIDTH-1:0] r_edgecap;
  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_prev;
  logic             r_irq;

  logic             w_wr;
  logic [WIDTH-1:0] w_wdata;
  logic [WIDTH-1:0] w_clr;
  logic [WIDTH-1:0] w_edge;
  logic             w_unused_wdata;

  assign w_wr    = chipselect & ~write_n;
  assign w_wdata = writedata[WIDTH-1:0];
  assign w_clr   = (w_wr && (address == c_ADDR_EDGECAP)) ? w_wdata : '0;
  // Bits above WIDTH are intentionally discarded.
  assign w_unused_wdata = ^writedata;

  generate
    if (EDGE_TYPE == 0) begin : g_edge_rise
      assign w_edge = r_sync2 & ~r_prev;
    end else if (EDGE_TYPE == 1) begin : g_edge_fall
      assign w_edge = ~r_sync2 & r_prev;
    end else begin : g_edge_any
      assign w_edge = r_sync2 ^ r_prev;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data_out <= RESET_VALUE;
      r_dir      <= DIR_RESET;
      r_irqmask  <= '0;
      r_edgecap  <= '0;
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_prev     <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_sync1   <= in_port;
      r_sync2   <= r_sync1;
      r_prev    <= r_sync2;
      // A fresh edge beats a simultaneous write-1-to-clear of the same bit.
      r_edgecap <= (r_edgecap & ~w_clr) | w_edge;
      r_irq     <= |(r_edgecap & r_irqmask);
      if (w_wr) begin
        case (address)
          c_ADDR_DATA:     r_data_out <= w_wdata;
          c_ADDR_DIR:      r_dir      <= w_wdata;
          c_ADDR_IRQMASK:  r_irqmask  <= w_wdata;
          c_ADDR_OUTSET:   r_data_out <= r_data_out | w_wdata;
          c_ADDR_OUTCLEAR: r_data_out <= r_data_out & ~w_wdata;
          default:         ;
        endcase
      end
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      c_ADDR_DATA:    readdata[WIDTH-1:0] = (r_dir & r_data_out) | (~r_dir & r_sync2);
      c_ADDR_DIR:     readdata[WIDTH-1:0] = r_dir;
      c_ADDR_IRQMASK: readdata[WIDTH-1:0] = r_irqmask;
      c_ADDR_EDGECAP: readdata[WIDTH-1:0] = r_edgecap;
      default:        ;
    endcase
  end

  assign out_port = r_data_out;
  assign oe       = r_dir;
  assign irq      = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_count_binary_pio.sv
`default_nettype none
// ============================================================================
// Module   : tb_count_binary_pio
// Purpose  : Scoreboard bench for count_binary_pio, one instance per EDGE_TYPE.
// Revision : 1.0
// ============================================================================
module tb_count_binary_pio;

  localparam logic [7:0] c_RV = 8'hA5;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in_port;

  logic [31:0] rd   [3];
  logic [7:0]  op   [3];
  logic [7:0]  oev  [3];
  logic        irqv [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    count_binary_pio #(
      .WIDTH(8), .RESET_VALUE(c_RV), .DIR_RESET(8'hFF), .EDGE_TYPE(g)
    ) u_dut (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(rd[g]),
      .in_port(in_port), .out_port(op[g]), .oe(oev[g]), .irq(irqv[g])
    );
  end

  // Reference model: register contents per instance, plus the history of
  // in_port values sampled at each clock edge (newest last).
  logic [7:0] m_data [3];
  logic [7:0] m_dir  [3];
  logic [7:0] m_mask [3];
  logic [7:0] m_ecap [3];
  logic       m_irq  [3];
  logic [7:0] hist [$];

  typedef struct {
    int          inst;
    int          kind;
    logic [31:0] val;
  } exp_t;

  exp_t  expq [$];
  exp_t  mx;
  logic [31:0] got;
  int    errors = 0;
  int    checks = 0;
  string kname [4] = '{"readdata", "out_port", "oe", "irq"};

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      m_data[i] = c_RV;
      m_dir[i]  = 8'hFF;
      m_mask[i] = 8'h00;
      m_ecap[i] = 8'h00;
      m_irq[i]  = 1'b0;
    end
    hist = '{8'h00, 8'h00, 8'h00};
  endfunction

  function automatic logic [7:0] edge_of(int mode, logic [7:0] s, logic [7:0] p);
    if (mode == 0) return s & ~p;
    if (mode == 1) return ~s & p;
    return (s & ~p) | (~s & p);
  endfunction

  function automatic logic [31:0] read_model(int i, logic [2:0] a);
    logic [7:0] insync;
    insync = hist[hist.size()-2];
    case (a)
      3'd0:    return {24'h0, (m_dir[i] & m_data[i]) | (~m_dir[i] & insync)};
      3'd1:    return {24'h0, m_dir[i]};
      3'd2:    return {24'h0, m_mask[i]};
      3'd3:    return {24'h0, m_ecap[i]};
      default: return 32'h0;
    endcase
  endfunction

  task automatic push_exp(int i, int k, logic [31:0] v);
    exp_t e;
    e.inst = i; e.kind = k; e.val = v;
    expq.push_back(e);
  endtask

  task automatic drive(logic rst, logic [2:0] a, logic cs, logic wn,
                       logic [31:0] wd, logic [7:0] inp);
    reset_n    = rst;
    address    = a;
    chipselect = cs;
    write_n    = wn;
    writedata  = wd;
    in_port    = inp;
    if (!rst) model_reset();
    for (int i = 0; i < 3; i++) begin
      push_exp(i, 0, read_model(i, a));
      push_exp(i, 1, {24'h0, m_data[i]});
      push_exp(i, 2, {24'h0, m_dir[i]});
      push_exp(i, 3, {31'h0, m_irq[i]});
    end
  endtask

  task automatic tick();
    logic [7:0] s, p, wd, clr, e;
    logic       wr;
    @(posedge clk);
    if (!reset_n) begin
      model_reset();
    end else begin
      s  = hist[hist.size()-2];
      p  = hist[hist.size()-3];
      wd = writedata[7:0];
      wr = chipselect && !write_n;
      for (int i = 0; i < 3; i++) begin
        clr = (wr && address == 3'd3) ? wd : 8'h00;
        e   = edge_of(i, s, p);
        m_irq[i]  = |(m_ecap[i] & m_mask[i]);
        m_ecap[i] = (m_ecap[i] & ~clr) | e;
        if (wr) begin
          case (address)
            3'd0: m_data[i] = wd;
            3'd1: m_dir[i]  = wd;
            3'd2: m_mask[i] = wd;
            3'd4: m_data[i] = m_data[i] | wd;
            3'd5: m_data[i] = m_data[i] & ~wd;
            default: ;
          endcase
        end
      end
      hist.push_back(in_port);
      void'(hist.pop_front());
    end
    #1;
  endtask

  // Monitor: outputs are presented between edges; compare on the falling edge.
  always @(negedge clk) begin
    while (expq.size() > 0) begin
      mx = expq.pop_front();
      case (mx.kind)
        0:       got = rd[mx.inst];
        1:       got = {24'h0, op[mx.inst]};
        2:       got = {24'h0, oev[mx.inst]};
        default: got = {31'h0, irqv[mx.inst]};
      endcase
      checks++;
      if (got !== mx.val) begin
        errors++;
        $display("FAIL %s inst%0d addr=%0d t=%0t: got %h expected %h",
                 kname[mx.kind], mx.inst, address, $time, got, mx.val);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; address = 3'd0; chipselect = 1'b0; write_n = 1'b1;
    writedata = 32'h0; in_port = 8'h00;
    model_reset();
    tick();

    // Reset state, then release.
    drive(1'b0, 3'd2, 1'b1, 1'b1, 32'h0, 8'h00); tick();
    drive(1'b0, 3'd3, 1'b1, 1'b1, 32'h0, 8'h00); tick();
    drive(1'b1, 3'd3, 1'b1, 1'b1, 32'h0, 8'h00); tick();

    // DATA / OUTSET / OUTCLEAR; out_port 0F, FF, FC.
    drive(1'b1, 3'd0, 1'b1, 1'b0, 32'hFFFF_FF0F, 8'h00); tick();
    drive(1'b1, 3'd4, 1'b1, 1'b0, 32'h0000_00F0, 8'h00); tick();
    drive(1'b1, 3'd5, 1'b1, 1'b0, 32'h0000_0003, 8'h00); tick();
    drive(1'b1, 3'd4, 1'b1, 1'b1, 32'h0, 8'h00);         tick();
    push_exp(0, 1, 32'h0000_00FC);
    drive(1'b1, 3'd5, 1'b1, 1'b1, 32'h0, 8'h00);         tick();

    // Mixed direction: DATA reads A5.
    drive(1'b1, 3'd1, 1'b1, 1'b0, 32'h0F, 8'hA0); tick();
    drive(1'b1, 3'd0, 1'b1, 1'b0, 32'h55, 8'hA0); tick();
    for (int n = 0; n < 3; n++) begin
      drive(1'b1, 3'd0, 1'b1, 1'b1, 32'h0, 8'hA0); tick();
    end
    drive(1'b1, 3'd0, 1'b1, 1'b1, 32'h0, 8'hA0);
    push_exp(0, 0, 32'h0000_00A5);
    push_exp(0, 2, 32'h0000_000F);
    tick();

    // Edge/irq latency on bit 0, then clear drops irq.
    drive(1'b1, 3'd2, 1'b1, 1'b0, 32'h01, 8'h00); tick();
    for (int n = 0; n < 4; n++) begin
      drive(1'b1, 3'd3, 1'b1, 1'b1, 32'h0, 8'h00); tick();
    end
    drive(1'b1, 3'd3, 1'b1, 1'b0, 32'hFF, 8'h00); tick();
    for (int n = 0; n < 5; n++) begin
      drive(1'b1, 3'd3, 1'b1, 1'b1, 32'h0, 8'h01); tick();
    end
    drive(1'b1, 3'd3, 1'b1, 1'b0, 32'h01, 8'h01); tick();
    for (int n = 0; n < 3; n++) begin
      drive(1'b1, 3'd3, 1'b1, 1'b1, 32'h0, 8'h01); tick();
    end

    // Falling edge: captured by EDGE_TYPE 1 and 2 only.
    drive(1'b1, 3'd3, 1'b1, 1'b0, 32'hFF, 8'h00); tick();
    for (int n = 0; n < 4; n++) begin
      drive(1'b1, 3'd3, 1'b1, 1'b1, 32'h0, 8'h00); tick();
    end
    drive(1'b1, 3'd3, 1'b1, 1'b0, 32'hFF, 8'h00); tick();

    // Collision: rising edge detected on the same edge as a clear of bit 0.
    drive(1'b1, 3'd3, 1'b1, 1'b1, 32'h0, 8'h01); tick();
    drive(1'b1, 3'd3, 1'b1, 1'b1, 32'h0, 8'h01); tick();
    drive(1'b1, 3'd3, 1'b1, 1'b0, 32'h01, 8'h01); tick();
    drive(1'b1, 3'd3, 1'b1, 1'b1, 32'h0, 8'h01);
    push_exp(0, 0, 32'h0000_0001);
    tick();

    // Mid-operation reset clears captures and irq immediately.
    drive(1'b1, 3'd2, 1'b1, 1'b0, 32'hFF, 8'h01); tick();
    drive(1'b1, 3'd3, 1'b1, 1'b1, 32'h0, 8'h00); tick();
    drive(1'b1, 3'd3, 1'b1, 1'b1, 32'h0, 8'h00); tick();
    drive(1'b0, 3'd3, 1'b1, 1'b1, 32'h0, 8'h00);
    push_exp(2, 0, 32'h0);
    push_exp(2, 3, 32'h0);
    tick();
    drive(1'b1, 3'd3, 1'b1, 1'b1, 32'h0, 8'h00); tick();

    // Randomised traffic.
    for (int n = 0; n < 400; n++) begin
      logic [7:0] inp;
      inp = ($urandom_range(0, 3) == 0) ? 8'($urandom) : in_port;
      drive(($urandom_range(0, 99) != 0), 3'($urandom), ($urandom_range(0, 3) != 0),
            1'($urandom), $urandom, inp);
      tick();
    end

    @(negedge clk);
    #1;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", expq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
